// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: word/half/byte loads and stores over a multi-cycle bus with an
// active-low ready handshake, a wait-state timeout, flush handling and a pipeline stall output.
module mem_access_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OFS_W   = 2,
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                EXEn,
  input  logic [3:0]          EXMemOp,
  input  logic [DATA_W-1:0]   EXMemWrData,
  input  logic [DATA_W-1:0]   EXOut,
  input  logic                Flush,
  input  logic [DATA_W-1:0]   BusRdData,
  input  logic                BusRdy_,
  output logic [ADDR_W-1:0]   BusAddr,
  output logic                BusAs_,
  output logic                BusRW,
  output logic [DATA_W/8-1:0] BusBE,
  output logic [DATA_W-1:0]   BusWrData,
  output logic [DATA_W-1:0]   Out,
  output logic                OutValid,
  output logic                Busy,
  output logic                MissAlign,
  output logic                BusErr
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic {StIdle, StAccess} state_t;
  typedef enum logic [1:0] {SzWord, SzHalf, SzByte} size_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  size_t               sz_q, sz_d;
  logic                sgn_q, sgn_d, ld_q, ld_d, drop_q, drop_d;
  logic [OFS_W-1:0]    ofs_q, ofs_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                as_q, as_d, rw_q, rw_d, ov_q, ov_d, ma_q, ma_d, err_q, err_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wd_q, wd_d, out_q, out_d;

  logic                dec_ld, dec_st, dec_sgn, aligned, dropped;
  size_t               dec_sz;
  logic [OFS_W-1:0]    ofs;
  logic [DATA_W-1:0]   shifted, ld_data;

  assign ofs     = EXOut[OFS_W-1:0];
  assign dropped = drop_q | Flush;

  always_comb begin
    dec_ld  = 1'b0;
    dec_st  = 1'b0;
    dec_sgn = 1'b0;
    dec_sz  = SzWord;
    case (EXMemOp)
      4'd1: dec_ld = 1'b1;
      4'd2: dec_st = 1'b1;
      4'd3: begin dec_ld = 1'b1; dec_sz = SzHalf; dec_sgn = 1'b1; end
      4'd4: begin dec_ld = 1'b1; dec_sz = SzHalf; end
      4'd5: begin dec_st = 1'b1; dec_sz = SzHalf; end
      4'd6: begin dec_ld = 1'b1; dec_sz = SzByte; dec_sgn = 1'b1; end
      4'd7: begin dec_ld = 1'b1; dec_sz = SzByte; end
      4'd8: begin dec_st = 1'b1; dec_sz = SzByte; end
      default: ;
    endcase
    case (dec_sz)
      SzWord:  aligned = (ofs == '0);
      SzHalf:  aligned = ~ofs[0];
      default: aligned = 1'b1;
    endcase
  end

  // Little-endian: the latched byte offset moves the selected lane down to bit 0.
  always_comb begin
    shifted = BusRdData >> {ofs_q, 3'b000};
    case (sz_q)
      SzHalf:  ld_data = {{(DATA_W-16){sgn_q & shifted[15]}}, shifted[15:0]};
      SzByte:  ld_data = {{(DATA_W-8){sgn_q & shifted[7]}}, shifted[7:0]};
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sz_d    = sz_q;
    sgn_d   = sgn_q;
    ld_d    = ld_q;
    ofs_d   = ofs_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    as_d    = as_q;
    rw_d    = rw_q;
    be_d    = be_q;
    wd_d    = wd_q;
    out_d   = out_q;
    ov_d    = 1'b0;
    ma_d    = 1'b0;
    err_d   = 1'b0;
    Busy    = 1'b0;
    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (EXEn && !Flush) begin
          if (!dec_ld && !dec_st) begin
            out_d = EXOut;
            ov_d  = 1'b1;
          end else if (!aligned) begin
            ma_d  = 1'b1;
            out_d = '0;
          end else begin
            Busy    = 1'b1;
            state_d = StAccess;
            cnt_d   = '0;
            addr_d  = EXOut[OFS_W+ADDR_W-1:OFS_W];
            as_d    = 1'b0;
            rw_d    = dec_ld;
            ld_d    = dec_ld;
            sz_d    = dec_sz;
            sgn_d   = dec_sgn;
            ofs_d   = ofs;
            case (dec_sz)
              SzHalf: begin
                be_d = BE_W'(2'b11) << ofs;
                wd_d = {(DATA_W/16){EXMemWrData[15:0]}};
              end
              SzByte: begin
                be_d = BE_W'(1'b1) << ofs;
                wd_d = {(DATA_W/8){EXMemWrData[7:0]}};
              end
              default: begin
                be_d = '1;
                wd_d = EXMemWrData;
              end
            endcase
            if (dec_ld) be_d = '1;
          end
        end
      end
      StAccess: begin
        Busy   = 1'b1;
        drop_d = dropped;
        if (!BusRdy_) begin
          state_d = StIdle;
          as_d    = 1'b1;
          be_d    = '0;
          drop_d  = 1'b0;
          if (!dropped) begin
            out_d = ld_q ? ld_data : '0;
            ov_d  = 1'b1;
          end
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = StIdle;
          as_d    = 1'b1;
          be_d    = '0;
          drop_d  = 1'b0;
          if (!dropped) begin
            out_d = '0;
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sz_q    <= SzWord;
      sgn_q   <= 1'b0;
      ld_q    <= 1'b0;
      ofs_q   <= '0;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      as_q    <= 1'b1;
      rw_q    <= 1'b1;
      be_q    <= '0;
      wd_q    <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      ma_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sz_q    <= sz_d;
      sgn_q   <= sgn_d;
      ld_q    <= ld_d;
      ofs_q   <= ofs_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      as_q    <= as_d;
      rw_q    <= rw_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      ma_q    <= ma_d;
      err_q   <= err_d;
    end
  end

  assign BusAddr   = addr_q;
  assign BusAs_    = as_q;
  assign BusRW     = rw_q;
  assign BusBE     = be_q;
  assign BusWrData = wd_q;
  assign Out       = out_q;
  assign OutValid  = ov_q;
  assign MissAlign = ma_q;
  assign BusErr    = err_q;

endmodule
